// File: rtl/fsmc_sdram_bridge.sv
// -----------------------------------------------------------------------------
// fsmc_sdram_bridge
//
// Bridges a small FSMC-style register window to a request/acknowledge SDRAM
// controller port. The host sets a word address (ADR_LOW/ADR_HIGH), pushes
// write data through DATA (buffered in a write queue), and requests single
// word reads by setting bit0 of an ADR_LOW write. Queued writes are always
// drained before a pending read is issued, so a read after a write returns
// the written data.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   fsmc_r_adr/r_data     register read address / combinational read data
//   fsmc_do_write         one-cycle register write strobe
//   fsmc_w_adr/w_data     register write address / data
//   o_adv                 request valid towards the SDRAM controller
//   o_rwn                 1 = read, 0 = write
//   o_addr, o_wdata       request word address / write data (held while o_adv)
//   i_ack                 controller accepted the request
//   i_write_done          write completed
//   i_data_valid, i_rdata read data return
//   i_idle                controller initialised and not busy
//
// Register map: 0 ADR_LOW, 1 ADR_HIGH, 2 DATA, 3 STATUS, others read 0.
// -----------------------------------------------------------------------------
module fsmc_sdram_bridge #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int SAW      = 27,
    parameter int WQ_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [AW-1:0]  fsmc_r_adr,
    output logic [DW-1:0]  fsmc_r_data,
    input  logic           fsmc_do_write,
    input  logic [AW-1:0]  fsmc_w_adr,
    input  logic [DW-1:0]  fsmc_w_data,
    output logic           o_adv,
    output logic           o_rwn,
    output logic [SAW-1:0] o_addr,
    output logic [DW-1:0]  o_wdata,
    input  logic           i_ack,
    input  logic           i_write_done,
    input  logic           i_data_valid,
    input  logic [DW-1:0]  i_rdata,
    input  logic           i_idle
);

    localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam int EW = SAW + DW;
    localparam int HW = SAW - 15;

    localparam logic [AW-1:0]  REG_ADR_LOW  = {AW{1'b0}};
    localparam logic [AW-1:0]  REG_ADR_HIGH = {{(AW-2){1'b0}}, 2'd1};
    localparam logic [AW-1:0]  REG_DATA     = {{(AW-2){1'b0}}, 2'd2};
    localparam logic [AW-1:0]  REG_STATUS   = {{(AW-2){1'b0}}, 2'd3};
    localparam logic [LW-1:0]  LEVEL_FULL   = LW'(WQ_DEPTH);
    localparam logic [LW-1:0]  LEVEL_ONE    = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]  PTR_ONE      = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [SAW-1:0] ADDR_ONE     = {{(SAW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_W = 3'd1,
        ST_WAIT_W  = 3'd2,
        ST_ISSUE_R = 3'd3,
        ST_WAIT_R  = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic           load_w_s;
    logic           load_r_s;
    logic           read_done_s;

    logic [EW-1:0]  mem_r [WQ_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [EW-1:0]  head_s;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           push_req_s;
    logic           push_ok_s;

    logic [SAW-1:0] addr_r;
    logic [SAW-1:0] addr_next_s;
    logic           rp_r;
    logic           ovf_r;
    logic           autoinc_r;
    logic [DW-1:0]  rdata_r;
    logic           busy_s;

    logic           we_adr_low_s;
    logic           we_adr_high_s;
    logic           we_data_s;
    logic           we_status_s;
    logic [DW-1:0]  rd_mux_s;

    assign we_adr_low_s  = fsmc_do_write && (fsmc_w_adr == REG_ADR_LOW);
    assign we_adr_high_s = fsmc_do_write && (fsmc_w_adr == REG_ADR_HIGH);
    assign we_data_s     = fsmc_do_write && (fsmc_w_adr == REG_DATA);
    assign we_status_s   = fsmc_do_write && (fsmc_w_adr == REG_STATUS);

    assign empty_s    = (level_r == {LW{1'b0}});
    assign full_s     = (level_r == LEVEL_FULL);
    assign head_s     = mem_r[rd_ptr_r];
    assign pop_s      = load_w_s;
    assign push_req_s = we_data_s;
    // A full queue still accepts a push when its head leaves in the same cycle.
    assign push_ok_s  = push_req_s && (!full_s || pop_s);
    assign busy_s     = !empty_s || rp_r || (state_r != ST_IDLE);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and request-load decode; queued writes beat a pending read
    always_comb begin
        state_next_s = state_r;
        load_w_s     = 1'b0;
        load_r_s     = 1'b0;
        read_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_idle && !empty_s) begin
                    state_next_s = ST_ISSUE_W;
                    load_w_s     = 1'b1;
                end else if (i_idle && rp_r) begin
                    state_next_s = ST_ISSUE_R;
                    load_r_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE_W: begin
                if (i_ack) begin
                    state_next_s = ST_WAIT_W;
                end else begin
                    state_next_s = ST_ISSUE_W;
                end
            end
            ST_WAIT_W: begin
                if (i_write_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_W;
                end
            end
            ST_ISSUE_R: begin
                if (i_ack) begin
                    state_next_s = ST_WAIT_R;
                end else begin
                    state_next_s = ST_ISSUE_R;
                end
            end
            ST_WAIT_R: begin
                if (i_data_valid) begin
                    state_next_s = ST_IDLE;
                    read_done_s  = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_R;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request outputs: o_adv follows the next state; fields only load on issue
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_adv   <= 1'b0;
            o_rwn   <= 1'b1;
            o_addr  <= {SAW{1'b0}};
            o_wdata <= {DW{1'b0}};
        end else begin
            o_adv <= (state_next_s == ST_ISSUE_W) || (state_next_s == ST_ISSUE_R);
            if (load_w_s) begin
                o_addr  <= head_s[EW-1:DW];
                o_wdata <= head_s[DW-1:0];
                o_rwn   <= 1'b0;
            end else if (load_r_s) begin
                o_addr  <= addr_r;
                o_rwn   <= 1'b1;
            end
        end
    end

    // Write queue storage, pointers and level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < WQ_DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {addr_r, fsmc_w_data};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Word address update: register writes override; a DATA push and a read
    // completion in the same cycle still advance the address only once
    always_comb begin
        addr_next_s = addr_r;
        if (we_adr_low_s) begin
            addr_next_s = {addr_r[SAW-1:15], fsmc_w_data[15:1]};
        end else if (we_adr_high_s) begin
            addr_next_s = {fsmc_w_data[HW-1:0], addr_r[14:0]};
        end else if (autoinc_r && (push_ok_s || read_done_s)) begin
            addr_next_s = addr_r + ADDR_ONE;
        end else begin
            addr_next_s = addr_r;
        end
    end

    // Control/status registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r    <= {SAW{1'b0}};
            rp_r      <= 1'b0;
            ovf_r     <= 1'b0;
            autoinc_r <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            addr_r <= addr_next_s;
            if (read_done_s) begin
                rp_r    <= 1'b0;
                rdata_r <= i_rdata;
            end else if (we_adr_low_s && fsmc_w_data[0]) begin
                rp_r <= 1'b1;
            end
            if (we_status_s) begin
                autoinc_r <= fsmc_w_data[3];
                if (fsmc_w_data[2]) begin
                    ovf_r <= 1'b0;
                end
            end else if (push_req_s && !push_ok_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Register read mux
    always_comb begin
        rd_mux_s = {DW{1'b0}};
        case (fsmc_r_adr)
            REG_ADR_LOW: begin
                rd_mux_s[15:0] = {addr_r[14:0], busy_s};
            end
            REG_ADR_HIGH: begin
                rd_mux_s[HW-1:0] = addr_r[SAW-1:15];
            end
            REG_DATA: begin
                rd_mux_s = rdata_r;
            end
            REG_STATUS: begin
                rd_mux_s[15:8] = {{(8-LW){1'b0}}, level_r};
                rd_mux_s[3:0]  = {autoinc_r, ovf_r, rp_r, busy_s};
            end
            default: begin
                rd_mux_s = {DW{1'b0}};
            end
        endcase
    end

    assign fsmc_r_data = rd_mux_s;

endmodule

// File: tb/tb_fsmc_sdram_bridge.sv
// -----------------------------------------------------------------------------
// tb_fsmc_sdram_bridge
//
// Directed scenarios plus a randomized phase. A small reference model keeps
// the host-visible word address, autoinc/overflow flags, last read value and
// an ordered list of the SDRAM writes that must appear on the request port.
// The bench plays the SDRAM controller (ack, write_done, data_valid).
// -----------------------------------------------------------------------------
module tb_fsmc_sdram_bridge;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int SAW = 27;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  fsmc_r_adr;
    logic [DW-1:0]  fsmc_r_data;
    logic           fsmc_do_write;
    logic [AW-1:0]  fsmc_w_adr;
    logic [DW-1:0]  fsmc_w_data;
    logic           o_adv;
    logic           o_rwn;
    logic [SAW-1:0] o_addr;
    logic [DW-1:0]  o_wdata;
    logic           i_ack;
    logic           i_write_done;
    logic           i_data_valid;
    logic [DW-1:0]  i_rdata;
    logic           i_idle;

    always #5 clk = ~clk;

    fsmc_sdram_bridge #(.DW(DW), .AW(AW), .SAW(SAW), .WQ_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .fsmc_r_adr   (fsmc_r_adr),
        .fsmc_r_data  (fsmc_r_data),
        .fsmc_do_write(fsmc_do_write),
        .fsmc_w_adr   (fsmc_w_adr),
        .fsmc_w_data  (fsmc_w_data),
        .o_adv        (o_adv),
        .o_rwn        (o_rwn),
        .o_addr       (o_addr),
        .o_wdata      (o_wdata),
        .i_ack        (i_ack),
        .i_write_done (i_write_done),
        .i_data_valid (i_data_valid),
        .i_rdata      (i_rdata),
        .i_idle       (i_idle)
    );

    int errors = 0;
    int checks = 0;

    // reference model
    logic [SAW-1:0]    m_addr;
    logic              m_autoinc;
    logic              m_ovf;
    logic [DW-1:0]     m_rdata;
    logic [SAW+DW-1:0] m_exp[$];

    logic [15:0] d;
    logic [15:0] val;
    logic [26:0] a;
    logic [14:0] rl;
    logic        ai;
    logic        do_rd;
    int          k;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] adr, input logic [15:0] wd);
        fsmc_w_adr    = adr;
        fsmc_w_data   = wd;
        fsmc_do_write = 1'b1;
        tick();
        fsmc_do_write = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] adr, output logic [15:0] v);
        fsmc_r_adr = adr;
        #1;
        v = fsmc_r_data;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] adr, input logic [15:0] exp);
        logic [15:0] v;
        reg_read(adr, v);
        chk(tag, {16'h0, v}, {16'h0, exp});
    endtask

    task automatic set_addr(input logic [26:0] na);
        reg_write(8'd1, {4'h0, na[26:15]});
        reg_write(8'd0, {na[14:0], 1'b0});
        m_addr = na;
    endtask

    task automatic push_data(input logic [15:0] wd, input logic accept);
        reg_write(8'd2, wd);
        if (accept) begin
            m_exp.push_back({m_addr, wd});
            if (m_autoinc) m_addr = m_addr + 27'd1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    function automatic logic [15:0] status_exp(input logic [7:0] lvl, input logic rp, input logic busy);
        return {lvl, 4'h0, m_autoinc, m_ovf, rp, busy};
    endfunction

    // act as the SDRAM controller for one request and check its fields
    task automatic serve(input logic rwn, input logic [26:0] ea, input logic [15:0] ewd,
                         input int hold, input logic [15:0] rd);
        int n = 0;
        while (o_adv !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("adv_wait", {31'h0, o_adv}, 32'd1);
        chk("req_rwn", {31'h0, o_rwn}, {31'h0, rwn});
        chk("req_addr", {5'h0, o_addr}, {5'h0, ea});
        if (!rwn) chk("req_wdata", {16'h0, o_wdata}, {16'h0, ewd});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_adv", {31'h0, o_adv}, 32'd1);
            chk("hold_addr", {5'h0, o_addr}, {5'h0, ea});
            chk("hold_rwn", {31'h0, o_rwn}, {31'h0, rwn});
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        chk("ack_drop", {31'h0, o_adv}, 32'd0);
        repeat ($urandom_range(0, 3)) tick();
        if (rwn) begin
            i_data_valid = 1'b1;
            i_rdata      = rd;
        end else begin
            i_write_done = 1'b1;
        end
        tick();
        i_data_valid = 1'b0;
        i_write_done = 1'b0;
    endtask

    task automatic serve_next(input int hold);
        logic [SAW+DW-1:0] e;
        e = m_exp.pop_front();
        serve(1'b0, e[SAW+DW-1:DW], e[DW-1:0], hold, 16'h0);
    endtask

    task automatic serve_read(input int hold, input logic [15:0] rd);
        serve(1'b1, m_addr, 16'h0, hold, rd);
        m_rdata = rd;
        if (m_autoinc) m_addr = m_addr + 27'd1;
    endtask

    initial begin
        rst = 1'b1;
        fsmc_r_adr = 8'd0; fsmc_do_write = 1'b0; fsmc_w_adr = 8'd0; fsmc_w_data = 16'h0;
        i_ack = 1'b0; i_write_done = 1'b0; i_data_valid = 1'b0; i_rdata = 16'h0; i_idle = 1'b0;
        m_addr = 27'h0; m_autoinc = 1'b0; m_ovf = 1'b0; m_rdata = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_adv", {31'h0, o_adv}, 32'd0);
        chk("rst_rwn", {31'h0, o_rwn}, 32'd1);
        chk("rst_addr", {5'h0, o_addr}, 32'd0);
        chk("rst_wdata", {16'h0, o_wdata}, 32'd0);
        chk_reg("rst_status", 8'd3, 16'h0000);
        chk_reg("rst_adr_low", 8'd0, 16'h0000);
        chk_reg("rst_data", 8'd2, 16'h0000);

        // autoinc sequence with latency check
        i_idle = 1'b1;
        reg_write(8'd3, 16'h0008);
        m_autoinc = 1'b1;
        reg_write(8'd1, 16'h0001);
        reg_write(8'd0, 16'h0010);
        m_addr = 27'h0008008;
        chk_reg("adr_low_wr", 8'd0, 16'h0010);
        chk_reg("adr_high_wr", 8'd1, 16'h0001);
        chk_reg("unmapped_rd", 8'd5, 16'h0000);
        push_data(16'h00A1, 1'b1);
        chk("lat_early", {31'h0, o_adv}, 32'd0);
        tick();
        chk("lat_2cyc", {31'h0, o_adv}, 32'd1);
        push_data(16'h00A2, 1'b1);
        serve_next(2);
        serve_next(0);
        chk_reg("inc_adr_low", 8'd0, 16'h0014);
        chk_reg("inc_adr_high", 8'd1, 16'h0001);

        // address wrap at the top of the space
        set_addr(27'h7FFFFFF);
        push_data(16'h1234 ^ 16'($urandom), 1'b1);
        serve_next(1);
        chk_reg("wrap_adr_low", 8'd0, 16'h0000);
        chk_reg("wrap_adr_high", 8'd1, 16'h0000);

        // overflow, then push on a full queue in its pop cycle
        i_idle = 1'b0;
        set_addr(27'h0123456);
        repeat (4) push_data(16'($urandom), 1'b1);
        push_data(16'hDEAD, 1'b0);
        chk_reg("ovf_status", 8'd3, 16'h040D);
        chk_reg("ovf_adr_low", 8'd0, {m_addr[14:0], 1'b1});
        reg_write(8'd3, 16'h000C);
        m_ovf = 1'b0;
        chk_reg("ovf_clear", 8'd3, 16'h0409);
        d = 16'($urandom);
        i_idle        = 1'b1;
        fsmc_w_adr    = 8'd2;
        fsmc_w_data   = d;
        fsmc_do_write = 1'b1;
        tick();
        fsmc_do_write = 1'b0;
        m_exp.push_back({m_addr, d});
        m_addr = m_addr + 27'd1;
        chk_reg("full_pushpop", 8'd3, 16'h0409);
        chk("full_pop_adv", {31'h0, o_adv}, 32'd1);
        while (m_exp.size() > 0) serve_next(int'($urandom_range(0, 2)));
        repeat (5) tick();
        chk("drained_adv", {31'h0, o_adv}, 32'd0);
        chk_reg("drained_status", 8'd3, 16'h0008);

        // read after queued writes
        i_idle = 1'b0;
        set_addr(27'($urandom));
        push_data(16'($urandom), 1'b1);
        push_data(16'($urandom), 1'b1);
        reg_write(8'd0, {m_addr[14:0], 1'b1});
        chk_reg("raw_status", 8'd3, status_exp(8'd2, 1'b1, 1'b1));
        i_idle = 1'b1;
        serve_next(0);
        serve_next(1);
        serve_read(10, 16'h5A5A);
        chk_reg("raw_data", 8'd2, 16'h5A5A);

        // reset in the middle of a read issue
        reg_write(8'd0, {m_addr[14:0], 1'b1});
        k = 0;
        while (o_adv !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("rr_adv", {31'h0, o_adv}, 32'd1);
        chk("rr_rwn", {31'h0, o_rwn}, 32'd1);
        chk("rr_addr", {5'h0, o_addr}, {5'h0, m_addr});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr_hold_adv", {31'h0, o_adv}, 32'd1);
            chk("rr_hold_addr", {5'h0, o_addr}, {5'h0, m_addr});
        end
        push_data(16'hBEEF, 1'b1);
        chk_reg("rr_status", 8'd3, status_exp(8'd1, 1'b1, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_adv", {31'h0, o_adv}, 32'd0);
        chk_reg("rst_async_status", 8'd3, 16'h0000);
        tick();
        rst = 1'b0;
        m_addr = 27'h0; m_autoinc = 1'b0; m_ovf = 1'b0; m_rdata = 16'h0;
        m_exp.delete();
        i_data_valid = 1'b1; i_write_done = 1'b1; i_ack = 1'b1; i_rdata = 16'hFFFF;
        tick();
        i_data_valid = 1'b0; i_write_done = 1'b0; i_ack = 1'b0;
        tick();
        chk("post_rst_adv", {31'h0, o_adv}, 32'd0);
        chk_reg("post_rst_data", 8'd2, 16'h0000);
        chk_reg("post_rst_status", 8'd3, 16'h0000);
        chk_reg("post_rst_adr_low", 8'd0, 16'h0000);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            ai = 1'($urandom_range(0, 1));
            reg_write(8'd3, {12'h000, ai, 1'b1, 2'b00});
            m_autoinc = ai;
            m_ovf     = 1'b0;
            i_idle    = 1'($urandom_range(0, 1));
            a = 27'($urandom);
            set_addr(a);
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) push_data(16'($urandom), 1'b1);
            do_rd = 1'($urandom_range(0, 1));
            if (do_rd) begin
                rl = 15'($urandom);
                reg_write(8'd0, {rl, 1'b1});
                m_addr = {m_addr[26:15], rl};
            end
            i_idle = 1'b1;
            while (m_exp.size() > 0) serve_next(int'($urandom_range(0, 3)));
            if (do_rd) serve_read(int'($urandom_range(0, 3)), 16'($urandom));
            chk_reg("rnd_data", 8'd2, m_rdata);
            chk_reg("rnd_adr_low", 8'd0, {m_addr[14:0], 1'b0});
            chk_reg("rnd_adr_high", 8'd1, {4'h0, m_addr[26:15]});
            chk_reg("rnd_status", 8'd3, status_exp(8'd0, 1'b0, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
